// File: rtl/gray_pkg.sv
// Shared Gray-code definitions used by the counter and by the Gray-to-binary decoder.
// Pure declarations; no state, no latency.
package gray_pkg;

   localparam int GRAY_W_DEFAULT = 4;
   localparam int GRAY_W_MAX     = 16;

   // Prefix-XOR decode from the MSB down; narrower codes are passed zero-extended.
   function automatic logic [GRAY_W_MAX-1:0] gray2bin(input logic [GRAY_W_MAX-1:0] i_gray);
      logic [GRAY_W_MAX-1:0] w_bin;
      w_bin[GRAY_W_MAX-1] = i_gray[GRAY_W_MAX-1];
      for (int i = GRAY_W_MAX-2; i >= 0; i--) begin
         w_bin[i] = w_bin[i+1] ^ i_gray[i];
      end
      return w_bin;
   endfunction

endpackage

// File: rtl/bin2gray.sv
// Binary to reflected Gray code: combinational, zero latency, no flow control.
module bin2gray #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] i_bin,
   output logic [WIDTH-1:0] o_gray
);

   assign o_gray = i_bin ^ (i_bin >> 1);

endmodule

// File: rtl/gray_code_counter.sv
// Up/down binary counter with registered Gray-code mirror and one-cycle wrap pulse.
// Outputs update one cycle after the controlling inputs; always accepts inputs, no backpressure.
module gray_code_counter
   import gray_pkg::*;
#(
   parameter int WIDTH = GRAY_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_bin,
   input  logic             en,
   input  logic             up_dn,
   output logic [WIDTH-1:0] bin_out,
   output logic [WIDTH-1:0] gray_out,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] ALL_ONES = '1;

   logic [WIDTH-1:0] r_bin;
   logic [WIDTH-1:0] r_gray;
   logic             r_wrap;
   logic [WIDTH-1:0] w_bin_nxt;
   logic [WIDTH-1:0] w_gray_nxt;
   logic             w_wrap_nxt;

   // Wrap only comes from a count step; clr/load jumps never flag it.
   always_comb begin
      w_bin_nxt  = r_bin;
      w_wrap_nxt = 1'b0;
      if (clr) begin
         w_bin_nxt = '0;
      end else if (load) begin
         w_bin_nxt = load_bin;
      end else if (en) begin
         if (up_dn) begin
            w_bin_nxt  = r_bin + 1'b1;
            w_wrap_nxt = (r_bin == ALL_ONES);
         end else begin
            w_bin_nxt  = r_bin - 1'b1;
            w_wrap_nxt = (r_bin == '0);
         end
      end
   end

   // Encoding the next value keeps gray_out aligned with bin_out with no output decode.
   bin2gray #(
      .WIDTH (WIDTH)
   ) u_bin2gray (
      .i_bin  (w_bin_nxt),
      .o_gray (w_gray_nxt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bin  <= '0;
         r_gray <= '0;
         r_wrap <= 1'b0;
      end else begin
         r_bin  <= w_bin_nxt;
         r_gray <= w_gray_nxt;
         r_wrap <= w_wrap_nxt;
      end
   end

   assign bin_out  = r_bin;
   assign gray_out = r_gray;
   assign wrap     = r_wrap;

endmodule

// File: tb/tb_gray_code_counter.sv
// Directed and randomized checks of gray_code_counter at WIDTH 4 and 8 against an arithmetic model.
module tb_gray_code_counter;
   import gray_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       clr;
   logic       load;
   logic       en;
   logic       up_dn;
   logic [3:0] load_bin4;
   logic [7:0] load_bin8;
   logic [3:0] bin4, gray4;
   logic [7:0] bin8, gray8;
   logic       wrap4, wrap8;

   int n_checks;
   int n_pass;
   int mb4, mb8;
   bit mw4, mw8;
   logic [3:0] prev_gray;

   gray_code_counter #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_bin(load_bin4),
      .en(en), .up_dn(up_dn), .bin_out(bin4), .gray_out(gray4), .wrap(wrap4)
   );

   gray_code_counter #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_bin(load_bin8),
      .en(en), .up_dn(up_dn), .bin_out(bin8), .gray_out(gray8), .wrap(wrap8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Reference behaviour, modulo arithmetic on plain integers.
   task automatic model_edge();
      if (!rst_n) begin
         mb4 = 0; mb8 = 0; mw4 = 0; mw8 = 0;
      end else if (clr) begin
         mb4 = 0; mb8 = 0; mw4 = 0; mw8 = 0;
      end else if (load) begin
         mb4 = int'(load_bin4); mb8 = int'(load_bin8); mw4 = 0; mw8 = 0;
      end else if (en) begin
         if (up_dn) begin
            mw4 = (mb4 == 15);  mb4 = (mb4 + 1) % 16;
            mw8 = (mb8 == 255); mb8 = (mb8 + 1) % 256;
         end else begin
            mw4 = (mb4 == 0); mb4 = (mb4 + 15) % 16;
            mw8 = (mb8 == 0); mb8 = (mb8 + 255) % 256;
         end
      end else begin
         mw4 = 0; mw8 = 0;
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".bin4"},  16'(bin4),  16'(mb4));
      check({tag, ".gray4"}, 16'(gray4), 16'(mb4 ^ (mb4 >> 1)));
      check({tag, ".wrap4"}, 16'(wrap4), 16'(mw4));
      check({tag, ".dec4"},  gray2bin(16'(gray4)), 16'(mb4));
      check({tag, ".bin8"},  16'(bin8),  16'(mb8));
      check({tag, ".gray8"}, 16'(gray8), 16'(mb8 ^ (mb8 >> 1)));
      check({tag, ".wrap8"}, 16'(wrap8), 16'(mw8));
      check({tag, ".dec8"},  gray2bin(16'(gray8)), 16'(mb8));
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic drive(input logic c, input logic l, input logic e, input logic u);
      clr = c; load = l; en = e; up_dn = u;
   endtask

   initial begin
      n_checks = 0; n_pass = 0;
      mb4 = 0; mb8 = 0; mw4 = 0; mw8 = 0;
      rst_n = 1'b0;
      drive(0, 0, 0, 1);
      load_bin4 = '0; load_bin8 = '0;

      // Reset state
      #3;
      check_all("reset");
      step("reset_hold");
      @(negedge clk);
      rst_n = 1'b1;

      // Full up sweep with single-bit Gray transitions
      drive(0, 0, 1, 1);
      for (int i = 0; i < 16; i++) begin
         prev_gray = gray4;
         step("up_sweep");
         check("up_hamming", 16'($countones(prev_gray ^ gray4)), 16'd1);
      end
      check("up_wrap_val", 16'({bin4, gray4, 3'b000, wrap4}), 16'h0001);
      step("up_wrap_clear");

      // Down wrap from a loaded zero
      drive(0, 1, 0, 0);
      load_bin4 = 4'd0; load_bin8 = 8'd0;
      step("load0");
      drive(0, 0, 1, 0);
      prev_gray = gray4;
      step("down_wrap");
      check("down_wrap_gray", 16'(gray4), 16'b1000);
      check("down_hamming", 16'($countones(prev_gray ^ gray4)), 16'd1);
      step("down_after");

      // Priority clr > load > en, then load alone
      drive(1, 1, 1, 1);
      load_bin4 = 4'd9; load_bin8 = 8'd9;
      step("prio_clr");
      drive(0, 1, 0, 1);
      step("prio_load");
      check("prio_load_gray", 16'(gray4), 16'b1101);

      // Load across the boundary does not flag wrap
      load_bin4 = 4'd15; load_bin8 = 8'd255;
      step("load_max");
      load_bin4 = 4'd0; load_bin8 = 8'd0;
      step("load_jump");

      // Hold and reversal
      drive(1, 0, 0, 1);
      step("rev_clr");
      drive(0, 0, 1, 1);
      for (int i = 0; i < 3; i++) step("rev_up");
      drive(0, 0, 0, 1);
      for (int i = 0; i < 3; i++) step("rev_hold");
      check("hold_val", 16'(bin4), 16'd3);
      drive(0, 0, 1, 0);
      for (int i = 0; i < 4; i++) step("rev_down");
      check("rev_wrap_15", 16'({bin4, 3'b000, wrap4}), 16'h00F1);

      // Back-to-back reversal across the boundary wraps twice
      drive(0, 0, 1, 1);
      step("bb_up");
      drive(0, 0, 1, 0);
      step("bb_down");

      // Randomized operation
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
               $urandom_range(0, 3) != 0, $urandom_range(0, 5) != 0);
         load_bin4 = 4'($urandom);
         load_bin8 = 8'($urandom);
         step("rand");
      end

      // Asynchronous reset mid-count at 5
      drive(1, 0, 0, 1);
      step("rst_clr");
      drive(0, 0, 1, 1);
      for (int i = 0; i < 5; i++) step("rst_count");
      #1;
      rst_n = 1'b0;
      mb4 = 0; mb8 = 0; mw4 = 0; mw8 = 0;
      #1;
      check_all("async_rst");
      step("rst_held");
      @(negedge clk);
      rst_n = 1'b1;
      step("rst_resume");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
